// File: rtl/integrator_chain.sv
// Pipelined cascade of NumStages wrapping integrators with per-channel accumulators,
// the integrator half of a multi-channel CIC decimator.
module integrator_chain #(
    parameter int InWidthBits  = 12,
    parameter int OutWidthBits = 24,
    parameter int NumStages    = 3,
    parameter int NumChannels  = 1,
    parameter int ChanBits     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [InWidthBits-1:0]  in,
    input  logic [ChanBits-1:0]     in_channel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OutWidthBits-1:0] out,
    output logic [ChanBits-1:0]     out_channel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    if (OutWidthBits < InWidthBits || NumStages < 1 || NumChannels < 1) begin : g_bad_params
        $error("integrator_chain: illegal parameter combination");
    end

    logic [NumStages-1:0][NumChannels-1:0][OutWidthBits-1:0] acc_q, acc_d;
    logic [NumStages-1:0][OutWidthBits-1:0] data_q, data_d;
    logic [NumStages-1:0][ChanBits-1:0]     chan_q, chan_d;
    logic [NumStages-1:0]                   vld_q, vld_d;

    // Inputs seen by each stage this cycle: stage 0 from the port, others from the stage before.
    logic [NumStages-1:0][OutWidthBits-1:0] stg_x;
    logic [NumStages-1:0][ChanBits-1:0]     stg_c;
    logic [NumStages-1:0]                   stg_v;

    logic                    advance;
    logic                    accept;
    logic                    chan_ok;
    logic [OutWidthBits-1:0] sum;

    assign advance  = !vld_q[NumStages-1] || out_ready;
    assign in_ready = advance || rst;
    assign accept   = in_valid && in_ready && !rst;
    // Out-of-range tags are consumed but travel as bubbles.
    assign chan_ok  = 32'(in_channel) < 32'(NumChannels);

    for (genvar gi = 0; gi < NumStages; gi++) begin : g_stage_in
        if (gi == 0) begin : g_first
            assign stg_x[gi] = OutWidthBits'($signed(in));
            assign stg_c[gi] = in_channel;
            assign stg_v[gi] = accept && chan_ok;
        end else begin : g_next
            assign stg_x[gi] = data_q[gi-1];
            assign stg_c[gi] = chan_q[gi-1];
            assign stg_v[gi] = vld_q[gi-1];
        end
    end

    always_comb begin
        acc_d  = acc_q;
        data_d = data_q;
        chan_d = chan_q;
        vld_d  = vld_q;
        sum    = '0;
        if (advance) begin
            for (int k = 0; k < NumStages; k++) begin
                vld_d[k] = stg_v[k];
                if (stg_v[k]) begin
                    sum = stg_x[k];
                    for (int c = 0; c < NumChannels; c++) begin
                        if (stg_c[k] == ChanBits'(c)) begin
                            sum         = acc_q[k][c] + stg_x[k];
                            acc_d[k][c] = sum;
                        end
                    end
                    data_d[k] = sum;
                    chan_d[k] = stg_c[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            data_q <= '0;
            chan_q <= '0;
            vld_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
            chan_q <= chan_d;
            vld_q  <= vld_d;
        end
    end

    assign out         = data_q[NumStages-1];
    assign out_channel = chan_q[NumStages-1];
    assign out_valid   = vld_q[NumStages-1];

endmodule
